// File: rtl/stream_pkt_arbiter_pkg.sv
// Shared types and helpers for stream_pkt_arbiter: FSM state encoding and
// round-robin pointer increment that wraps at an arbitrary requester count.
package stream_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Pointer increment wraps at n-1, not at the next power of two.
    function automatic logic [31:0] rr_next(input logic [31:0] ptr, input logic [31:0] n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/stream_pkt_arbiter_rr_pick.sv
// Round-robin winner selection: first set request at or above ptr_i,
// wrapping from N_REQ-1 back to 0 (rotate, priority-encode, un-rotate).
module rr_pick #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ID_WIDTH = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]    req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic                any_req_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    always_comb begin
        logic [31:0] pos;
        pos       = '0;
        any_req_o = 1'b0;
        idx_o     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = 32'(ptr_i) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!any_req_o && req_i[pos[ID_WIDTH-1:0]]) begin
                any_req_o = 1'b1;
                idx_o     = pos[ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-level round-robin arbiter feeding one narrow stream consumer.
// Define STREAM_ARB_OUT_REG_EN to register m_* through a one-entry output stage.
module stream_pkt_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 4,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned ID_WIDTH     = $clog2(N_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_REQ-1:0][T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [N_REQ-1:0]                     s_last_i,
    input  logic [N_REQ-1:0]                     s_valid_i,
    output logic [N_REQ-1:0]                     s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i,
    output logic [ID_WIDTH-1:0]                  m_id_o
);

    arb_state_e              state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic                    any_req;
    logic [ID_WIDTH-1:0]     pick;
    logic                    grant_valid, grant_last, grant_ready, beat_hs;
    logic [T_DATA_WIDTH-1:0] grant_data;

    rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req_i     (s_valid_i),
        .ptr_i     (rr_ptr_q),
        .any_req_o (any_req),
        .idx_o     (pick)
    );

    assign grant_valid = s_valid_i[grant_q];
    assign grant_last  = s_last_i[grant_q];
    assign grant_data  = s_data_i[grant_q];
    assign beat_hs     = (state_q == ARB_LOCKED) && grant_valid && grant_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (beat_hs && grant_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ID_WIDTH'(rr_next(32'(grant_q), 32'(N_REQ)));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

`ifdef STREAM_ARB_OUT_REG_EN
    logic                    out_valid_q;
    logic [T_DATA_WIDTH-1:0] out_data_q;
    logic                    out_last_q;
    logic [ID_WIDTH-1:0]     out_id_q;

    // The register accepts a new beat whenever it is empty or draining.
    assign grant_ready = !out_valid_q || m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else if (grant_ready) begin
            out_valid_q <= beat_hs;
            out_data_q  <= grant_data;
            out_last_q  <= grant_last;
            out_id_q    <= grant_q;
        end
    end

    always_comb begin
        s_ready_o = '0;
        if (state_q == ARB_LOCKED) begin
            s_ready_o[grant_q] = grant_ready;
        end
        m_valid_o = out_valid_q;
        m_data_o  = out_data_q;
        m_last_o  = out_last_q;
        m_id_o    = out_id_q;
    end
`else
    assign grant_ready = m_ready_i;

    always_comb begin
        s_ready_o = '0;
        m_valid_o = 1'b0;
        m_data_o  = '0;
        m_last_o  = 1'b0;
        m_id_o    = grant_q;
        if (state_q == ARB_LOCKED) begin
            s_ready_o[grant_q] = grant_ready;
            m_valid_o          = grant_valid;
            m_data_o           = grant_data;
            m_last_o           = grant_last;
        end
    end
`endif

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Self-checking bench for stream_pkt_arbiter (combinational output build),
// with an N_REQ=3 instance for the pointer wrap case.
module tb_stream_pkt_arbiter;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][W-1:0] s_data;
    logic [N-1:0]        s_last, s_valid, s_ready;
    logic [W-1:0]        m_data;
    logic                m_last, m_valid, m_ready;
    logic [IW-1:0]       m_id;

    logic [2:0][W-1:0]   s3_data;
    logic [2:0]          s3_last, s3_valid, s3_ready;
    logic [W-1:0]        m3_data;
    logic                m3_last, m3_valid, m3_ready;
    logic [1:0]          m3_id;

    stream_pkt_arbiter #(.T_DATA_WIDTH(W), .N_REQ(N)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_id_o(m_id)
    );

    stream_pkt_arbiter #(.T_DATA_WIDTH(W), .N_REQ(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s3_data), .s_last_i(s3_last), .s_valid_i(s3_valid), .s_ready_o(s3_ready),
        .m_data_o(m3_data), .m_last_o(m3_last), .m_valid_o(m3_valid), .m_ready_i(m3_ready),
        .m_id_o(m3_id)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic          last;
    } exp_t;

    exp_t expq[$];
    exp_t exp3[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0] bdata[N][16];
    logic         blast[N][16];
    int           nb[N], ptr[N], stall[N], gap_at[N];
    int           gap_len;
    logic         hs[N];
    int           cyc = 0, seen = 0, seen3 = 0, prev_cyc = 0;
    logic         prev_last, have_prev, check_tput, toggle_ready;

    task automatic clear_driver();
        for (int r = 0; r < N; r++) begin
            nb[r] = 0; ptr[r] = 0; stall[r] = 0; gap_at[r] = -1; hs[r] = 1'b0;
        end
        gap_len = 0;
        s_valid = '0; s_data = '0; s_last = '0;
        m_ready = 1'b1;
        expq.delete();
        have_prev = 1'b0; prev_last = 1'b0;
        check_tput = 1'b0; toggle_ready = 1'b0;
        seen = 0;
    endtask

    task automatic load_packet(input int r, input int len, input logic [W-1:0] base);
        exp_t e;
        for (int b = 0; b < len; b++) begin
            bdata[r][nb[r]] = base + W'(b);
            blast[r][nb[r]] = (b == len - 1);
            e.id   = IW'(r);
            e.data = base + W'(b);
            e.last = (b == len - 1);
            expq.push_back(e);
            nb[r]++;
        end
    endtask

    task automatic advance();
        for (int r = 0; r < N; r++) begin
            if (stall[r] > 0) stall[r]--;
            if (hs[r]) begin
                ptr[r]++;
                if (ptr[r] == gap_at[r]) stall[r] = gap_len;
            end
        end
        if (toggle_ready) m_ready = ~m_ready;
    endtask

    task automatic apply();
        for (int r = 0; r < N; r++) begin
            if (stall[r] == 0 && ptr[r] < nb[r]) begin
                s_valid[r] = 1'b1;
                s_data[r]  = bdata[r][ptr[r]];
                s_last[r]  = blast[r][ptr[r]];
            end else begin
                s_valid[r] = 1'b0;
                s_data[r]  = '0;
                s_last[r]  = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic [N-1:0] exp_rdy;
        exp_t got, e;
        int gap;
        n_checks++;
        if ($countones(s_ready) > 1) begin
            n_fail++;
            $display("FAIL ready_onehot: s_ready_o=%b, required at most one bit", s_ready);
        end
        if (m_valid === 1'b1) begin
            exp_rdy = '0;
            if (m_ready) exp_rdy[m_id] = 1'b1;
            n_checks++;
            if (s_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL ready_route: s_ready_o=%b required %b", s_ready, exp_rdy);
            end
        end
        for (int r = 0; r < N; r++) hs[r] = s_valid[r] && s_ready[r];
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            got = {m_id, m_data, m_last};
            n_checks++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: id=%0d data=%h last=%b with empty scoreboard", m_id, m_data, m_last);
            end else begin
                e = expq.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL beat: got id=%0d data=%h last=%b required id=%0d data=%h last=%b",
                             got.id, got.data, got.last, e.id, e.data, e.last);
                end
            end
            seen++;
            if (check_tput) begin
                if (have_prev) begin
                    gap = prev_last ? 2 : 1;
                    n_checks++;
                    if (cyc - prev_cyc != gap) begin
                        n_fail++;
                        $display("FAIL beat_spacing: got %0d cycles required %0d", cyc - prev_cyc, gap);
                    end
                end
                have_prev = 1'b1;
                prev_cyc  = cyc;
                prev_last = m_last;
            end
        end
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        advance();
        apply();
    endtask

    task automatic wait_seen(input int target, input int budget);
        int k = 0;
        while (seen < target && k < budget) begin
            cycle();
            k++;
        end
    endtask

    task automatic drain(input int budget, input string name);
        int k = 0;
        while (expq.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        repeat (3) cycle();
        n_checks++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, expq.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_driver();
        s3_valid = '0; s3_last = '0; s3_data = '0; m3_ready = 1'b1;
        exp3.delete();
        seen3 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = '1; s_last = '1; s_data = '1; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        n_checks += 5;
        if (s_ready !== '0)   begin n_fail++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
        if (m_last !== 1'b0)  begin n_fail++; $display("FAIL reset_m_last: got %b required 0", m_last); end
        if (m_data !== '0)    begin n_fail++; $display("FAIL reset_m_data: got %h required 0", m_data); end
        if (m_id !== '0)      begin n_fail++; $display("FAIL reset_m_id: got %0d required 0", m_id); end
        do_reset();
        #2;
        n_checks += 3;
        if (s_ready !== '0)   begin n_fail++; $display("FAIL idle_s_ready: got %b required 0", s_ready); end
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL idle_m_valid: got %b required 0", m_valid); end
        if (m3_valid !== 1'b0) begin n_fail++; $display("FAIL idle_m3_valid: got %b required 0", m3_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        check_tput = 1'b1;
        load_packet(0, 2, 4'h0);
        load_packet(1, 2, 4'h4);
        load_packet(2, 2, 4'h8);
        load_packet(3, 2, 4'hC);
        load_packet(0, 2, 4'h2);
        apply();
        drain(60, "round_robin");
    endtask

    task automatic test_hold_packet();
        do_reset();
        load_packet(2, 3, 4'h1);
        apply();
        wait_seen(1, 20);
        load_packet(1, 2, 4'h5);
        apply();
        drain(40, "hold_packet");
    endtask

    task automatic test_valid_drop();
        int k = 0;
        do_reset();
        gap_at[0] = 2;
        gap_len   = 3;
        load_packet(0, 4, 4'h0);
        load_packet(1, 1, 4'h8);
        load_packet(2, 1, 4'h9);
        apply();
        while (ptr[0] < 2 && k < 20) begin
            cycle();
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks += 3;
            if (m_valid !== 1'b0) begin n_fail++; $display("FAIL drop_m_valid: got %b required 0", m_valid); end
            if ((s_ready & 4'b1110) !== 4'b0000) begin
                n_fail++; $display("FAIL drop_other_ready: got %b required 000x", s_ready);
            end
            if (m_id !== 2'd0) begin n_fail++; $display("FAIL drop_m_id: got %0d required 0", m_id); end
            cycle();
        end
        drain(40, "valid_drop");
    endtask

    task automatic test_ready_toggle();
        do_reset();
        toggle_ready = 1'b1;
        load_packet(3, 4, 4'h4);
        apply();
        drain(40, "ready_toggle");
        toggle_ready = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic cycle3();
        exp_t got, e;
        @(negedge clk);
        if (m3_valid === 1'b1 && m3_ready === 1'b1) begin
            got = {m3_id, m3_data, m3_last};
            n_checks++;
            if (exp3.size() == 0) begin
                n_fail++;
                $display("FAIL n3_unexpected_beat: id=%0d data=%h", m3_id, m3_data);
            end else begin
                e = exp3.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL n3_beat: got id=%0d data=%h required id=%0d data=%h", got.id, got.data, e.id, e.data);
                end
            end
            seen3++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait3(input int target);
        int k = 0;
        while (seen3 < target && k < 20) begin
            cycle3();
            k++;
        end
        n_checks++;
        if (seen3 < target) begin
            n_fail++;
            $display("FAIL n3_timeout: got %0d beats required %0d", seen3, target);
        end
    endtask

    task automatic test_wrap_n3();
        do_reset();
        s3_last = '1;
        s3_data[2] = 4'hA; s3_valid = 3'b100; exp3.push_back({2'd2, 4'hA, 1'b1});
        wait3(1);
        s3_data[0] = 4'h5; s3_valid = 3'b001; exp3.push_back({2'd0, 4'h5, 1'b1});
        wait3(2);
        s3_data[2] = 4'hB; s3_data[0] = 4'h6; s3_valid = 3'b101; exp3.push_back({2'd2, 4'hB, 1'b1});
        wait3(3);
        s3_valid = 3'b001; exp3.push_back({2'd0, 4'h6, 1'b1});
        wait3(4);
        s3_valid = '0;
        repeat (3) cycle3();
        n_checks++;
        if (exp3.size() != 0) begin
            n_fail++;
            $display("FAIL n3_drain: %0d beats outstanding, required 0", exp3.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        load_packet(1, 3, 4'h7);
        apply();
        wait_seen(1, 20);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid: got %b required 0", m_valid); end
        if (s_ready !== '0)   begin n_fail++; $display("FAIL midrst_s_ready: got %b required 0", s_ready); end
        if (m_data !== '0)    begin n_fail++; $display("FAIL midrst_m_data: got %h required 0", m_data); end
        if (m_last !== 1'b0)  begin n_fail++; $display("FAIL midrst_m_last: got %b required 0", m_last); end
        if (m_id !== '0)      begin n_fail++; $display("FAIL midrst_m_id: got %0d required 0", m_id); end
        clear_driver();
        load_packet(0, 2, 4'hA);
        load_packet(1, 1, 4'hE);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply();
        drain(40, "reset_mid_packet");
    endtask

    initial begin
        clear_driver();
        s3_valid = '0; s3_last = '0; s3_data = '0; m3_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_hold_packet();
        test_valid_drop();
        test_ready_toggle();
        test_wrap_n3();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule

// File: doc/stream_pkt_arbiter.md
# stream_pkt_arbiter

Packet-level round-robin arbiter that shares one narrow stream consumer, normally a `stream_upsize` instance, between `N_REQ` narrow requester streams. It grants one requester at a time and holds the grant until that requester's `last` beat is accepted, so packets are never interleaved and `stream_upsize` keep/last framing stays correct. It sits directly in front of `stream_upsize` and adds a source ID sideband for the packed output.

## Interface
- `T_DATA_WIDTH`, default 4: width of one narrow beat.
- `N_REQ`, default 4: number of requester streams; must be ≥ 2 and need not be a power of two.
- `ID_WIDTH`, default `$clog2(N_REQ)`: width of the source ID.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_data_i`  in  `[N_REQ-1:0][T_DATA_WIDTH-1:0]`  requester beats.
- `s_last_i`  in  `N_REQ`  last beat of a packet, per requester.
- `s_valid_i`  in  `N_REQ`  per-requester valid.
- `s_ready_o`  out  `N_REQ`  per-requester ready; at most one bit is high.
- `m_data_o`  out  `T_DATA_WIDTH`  granted beat, driven to `stream_upsize` `s_data_i`.
- `m_last_o`  out  1  granted last.
- `m_valid_o`  out  1  output valid.
- `m_ready_i`  in  1  downstream ready, from `stream_upsize` `s_ready_o`.
- `m_id_o`  out  `ID_WIDTH`  index of the granted requester; stable for the whole packet.

## Operation
FSM states:
- **IDLE**
  - `s_ready_o = 0`; `m_valid_o = 0`.
  - If any `s_valid_i` is set: pick the first set bit searching upward from `rr_ptr`, wrapping from `N_REQ-1` to 0.
  - Register the winner in `grant`, then go to LOCKED.
  - No beat is transferred in IDLE.
- **LOCKED**
  - Datapath muxes requester `grant`:
    - `m_data_o`/`m_last_o` = `s_data_i[grant]`/`s_last_i[grant]`
    - `m_valid_o = s_valid_i[grant]`
    - `s_ready_o[grant] = m_ready_i`; all other ready bits are 0.
  - `m_id_o = grant`.
  - Beat handshake occurs when `s_valid_i[grant] && s_ready_o[grant]`.
  - A handshake with `s_last_i[grant]=1` goes to IDLE and sets `rr_ptr` to `grant+1` mod `N_REQ`.
  - If the granted requester drops valid mid-packet, the grant is held indefinitely. There is no preemption.
- Requests from non-granted requesters are ignored and need not be stable. The granted requester must hold data stable while valid and not ready, per the standard valid/ready rule.
- `rr_ptr` is `ID_WIDTH` wide and wraps at `N_REQ-1` to 0, not at `2**ID_WIDTH`.

## Timing
- Reset: state IDLE, `rr_ptr=0`, `grant=0`.
  - Outputs at reset: `s_ready_o=0`, `m_valid_o=0`, `m_last_o=0`, `m_data_o=0`, `m_id_o=0`.
- Arbitration latency is one cycle: a request seen in IDLE at edge k gives the first beat possible at edge k+1.
- Throughput within a packet is one beat per cycle. Each packet costs exactly one bubble cycle between packets.
- A single-beat packet occupies 2 cycles (IDLE, then LOCKED).
- Simultaneous `last` handshake and new requests: the new pick happens in the following IDLE cycle, never in the same cycle.
- `rst_n` asserted mid-packet: immediate return to reset values. The partial packet is abandoned, and the downstream is reset by the same `rst_n`.
- Without `STREAM_ARB_OUT_REG_EN`, `m_*` depends combinationally on `s_*` and `m_ready_i`.

## Configuration
- `STREAM_ARB_OUT_REG_EN` defined: `m_data_o`, `m_last_o`, `m_valid_o` and `m_id_o` come from a one-entry output register.
  - Register load enable is `!m_valid_o || m_ready_i`.
  - `s_ready_o[grant]` equals that load enable while LOCKED.
  - LOCKED exits when the last beat is loaded into the register.
  - The next arbitration may overlap with the register draining.
  - Adds one cycle of latency; full throughput is kept.
  - Register resets to 0/invalid.
- Undefined: pure combinational pass-through, as described above.

## Structure
- Package `stream_arb_pkg`:
  - state enum `arb_state_e {ARB_IDLE, ARB_LOCKED}`
  - function `rr_next(ptr, n)` implementing wrap-around increment.
- Sub-module `rr_pick` (combinational):
  - inputs: request vector, `rr_ptr`
  - outputs: `any_req`, winner index
  - rotate, priority-encode, un-rotate.

## Test plan
- All four requesters valid, each sending 2-beat packets; `m_ready_i=1` → `m_id_o` sequence 0,1,2,3,0 with one idle cycle between packets; no interleaving.
- Requester 2 sends 3 beats `0x1,0x2,0x3`. Requester 1 raises valid during beat 2 → requester 1 is granted only after the `last` beat `0x3` is accepted.
- Granted requester drops valid for 3 cycles mid-packet while others request → grant is held; `m_valid_o=0`; no other `s_ready_o` bit is high.
- `m_ready_i` toggles every cycle during a 4-beat packet → every beat is delivered exactly once, in order, and `s_ready_o[grant]` mirrors `m_ready_i`.
- `N_REQ=3`, only requester 2 active, then requester 0 → `rr_ptr` wraps 2→0 and requester 0 is granted next.
- Reset asserted on the second beat of a packet → outputs are 0 at once; after release, requester 0 wins first if valid.
